// File: rtl/bp_io_cmd_throttle_if.sv
// Command/response handshake bundle between the nbf loader, the throttle and the cce-to-mem link.
// Signal names are from the throttle's point of view; the master modport is the surrounding environment.
interface bp_io_cmd_throttle_if #(
    parameter int msg_width_p = 512
);
    logic [msg_width_p-1:0] cmd_i;
    logic                   cmd_v_i;
    logic                   cmd_ready_o;
    logic [msg_width_p-1:0] cmd_o;
    logic                   cmd_v_o;
    logic                   cmd_ready_i;
    logic [msg_width_p-1:0] resp_i;
    logic                   resp_v_i;
    logic                   resp_ready_o;
    logic [msg_width_p-1:0] resp_o;
    logic                   resp_v_o;
    logic                   resp_yumi_i;

    modport slave (
        input  cmd_i, cmd_v_i, cmd_ready_i, resp_i, resp_v_i, resp_yumi_i,
        output cmd_ready_o, cmd_o, cmd_v_o, resp_ready_o, resp_o, resp_v_o
    );

    modport master (
        output cmd_i, cmd_v_i, cmd_ready_i, resp_i, resp_v_i, resp_yumi_i,
        input  cmd_ready_o, cmd_o, cmd_v_o, resp_ready_o, resp_o, resp_v_o
    );
endinterface

// File: rtl/bp_io_cmd_throttle.sv
// Credit throttle with fence between the nbf loader and the cce-to-mem link.
// Optional watchdog on stalled responses: define BP_IO_THROTTLE_WATCHDOG_EN.
module bp_io_cmd_throttle #(
    parameter  int max_outstanding_p = 16,
    parameter  int timeout_p         = 4096,
    localparam int CW                = $clog2(max_outstanding_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_io_cmd_throttle_if.slave     io,
    input  logic                    fence_i,
    output logic                    fence_done_o,
    output logic [CW-1:0]           outstanding_o,
    output logic                    err_o,
    output logic                    state_o
);
    // Handshake rules: the link side transfers on valid & ready; the loader side
    // uses yumi, so resp_ready_o is simply the loader's consume strobe.
    typedef enum logic {ST_RUN = 1'b0, ST_FENCE = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic          r_err;
    logic          w_issue_ok;
    logic          w_inc;
    logic          w_dec;
    logic          w_underflow;
    logic          w_dec_ok;
    logic          w_wd_hit;

    assign w_issue_ok = (r_state == ST_RUN) && (r_count < CW'(max_outstanding_p));

    assign io.cmd_o        = io.cmd_i;
    assign io.cmd_v_o      = io.cmd_v_i & w_issue_ok & ~reset_i;
    assign io.cmd_ready_o  = io.cmd_ready_i & w_issue_ok & ~reset_i;
    assign io.resp_o       = io.resp_i;
    assign io.resp_v_o     = io.resp_v_i & ~reset_i;
    assign io.resp_ready_o = io.resp_yumi_i & ~reset_i;

    assign w_inc       = io.cmd_v_o & io.cmd_ready_i;
    assign w_dec       = io.resp_v_o & io.resp_yumi_i;
    // A response with nothing outstanding is still delivered but never decrements.
    assign w_underflow = w_dec & (r_count == '0);
    assign w_dec_ok    = w_dec & ~w_underflow;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (w_inc && !w_dec_ok) begin
            r_count <= r_count + 1'b1;
        end else if (!w_inc && w_dec_ok) begin
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (fence_i)  w_state_nxt = ST_FENCE;
            ST_FENCE: if (!fence_i) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

`ifdef BP_IO_THROTTLE_WATCHDOG_EN
    localparam int WW = $clog2(timeout_p + 1);

    logic [WW-1:0] r_wd;
    logic          w_wd_clr;

    assign w_wd_clr = w_dec | (r_count == '0);
    // Fires on the edge where the counter steps onto timeout_p; it then stays saturated.
    assign w_wd_hit = ~w_wd_clr & (r_wd == WW'(timeout_p - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wd <= '0;
        end else if (w_wd_clr) begin
            r_wd <= '0;
        end else if (r_wd != WW'(timeout_p)) begin
            r_wd <= r_wd + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (timeout_p == 0);
    assign w_wd_hit         = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else if (w_underflow || w_wd_hit) begin
            r_err <= 1'b1;
        end
    end

    assign fence_done_o  = (r_state == ST_FENCE) & (r_count == '0) & ~reset_i;
    assign outstanding_o = r_count;
    assign err_o         = r_err;
    assign state_o       = r_state;
endmodule

// File: tb/tb_bp_io_cmd_throttle.sv
// Directed bench for bp_io_cmd_throttle: credit limit, release, same-cycle traffic, fence, underflow, watchdog.
// Inputs change on the falling edge; outputs are sampled 1ns later, away from the rising edge.
module tb_bp_io_cmd_throttle;
    localparam int MSG_W   = 32;
    localparam int MAX_OUT = 4;
    localparam int TMO     = 32;
    localparam int CW      = $clog2(MAX_OUT + 1);

    logic          clk_i;
    logic          reset_i;
    logic          fence_i;
    logic          fence_done_o;
    logic [CW-1:0] outstanding_o;
    logic          err_o;
    logic          state_o;

    int checks = 0;
    int errors = 0;

    bp_io_cmd_throttle_if #(.msg_width_p(MSG_W)) io ();

    bp_io_cmd_throttle #(
        .max_outstanding_p(MAX_OUT),
        .timeout_p        (TMO)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .io           (io),
        .fence_i      (fence_i),
        .fence_done_o (fence_done_o),
        .outstanding_o(outstanding_o),
        .err_o        (err_o),
        .state_o      (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic set_resp(input logic v, input logic [MSG_W-1:0] d);
        io.resp_v_i    = v;
        io.resp_yumi_i = v;
        io.resp_i      = d;
    endtask

    task automatic test_reset();
        reset_i        = 1'b1;
        fence_i        = 1'b1;
        io.cmd_i       = 32'hdead_0000;
        io.cmd_v_i     = 1'b1;
        io.cmd_ready_i = 1'b1;
        set_resp(1'b1, 32'h1234_5678);
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (io.cmd_v_o !== 1'b0) begin errors++; $display("FAIL rst_cmd_v got %0b exp 0", io.cmd_v_o); end
        checks++; if (io.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %0b exp 0", io.cmd_ready_o); end
        checks++; if (io.resp_v_o !== 1'b0) begin errors++; $display("FAIL rst_resp_v got %0b exp 0", io.resp_v_o); end
        checks++; if (io.resp_ready_o !== 1'b0) begin errors++; $display("FAIL rst_resp_ready got %0b exp 0", io.resp_ready_o); end
        checks++; if (fence_done_o !== 1'b0) begin errors++; $display("FAIL rst_fence_done got %0b exp 0", fence_done_o); end
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", outstanding_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err_o); end
        @(negedge clk_i);
        reset_i    = 1'b0;
        fence_i    = 1'b0;
        io.cmd_v_i = 1'b0;
        set_resp(1'b0, '0);
        #1;
        checks++; if (state_o !== 1'b0) begin errors++; $display("FAIL rst_state got %0b exp RUN", state_o); end
    endtask

    task automatic test_credit_limit();
        int acc;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            io.cmd_i   = 32'hc000_0000 + i;
            io.cmd_v_i = 1'b1;
            #1;
            if (io.cmd_v_o && io.cmd_ready_i) acc++;
            if (i == 0) begin
                checks++; if (io.cmd_o !== 32'hc000_0000) begin errors++; $display("FAIL cmd_data got %0h exp c0000000", io.cmd_o); end
            end
        end
        checks++; if (acc != 4) begin errors++; $display("FAIL credit_accepted got %0d exp 4", acc); end
        @(negedge clk_i);
        #1;
        checks++; if (io.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL credit_ready_full got %0b exp 0", io.cmd_ready_o); end
        checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL credit_count got %0d exp 4", outstanding_o); end
    endtask

    task automatic test_resp_frees();
        @(negedge clk_i);
        set_resp(1'b1, 32'hbeef_0001);
        #1;
        checks++; if (io.resp_v_o !== 1'b1) begin errors++; $display("FAIL free_resp_v got %0b exp 1", io.resp_v_o); end
        checks++; if (io.resp_o !== 32'hbeef_0001) begin errors++; $display("FAIL free_resp_data got %0h exp beef0001", io.resp_o); end
        checks++; if (io.resp_ready_o !== 1'b1) begin errors++; $display("FAIL free_resp_ready got %0b exp 1", io.resp_ready_o); end
        checks++; if (io.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL free_same_cycle_ready got %0b exp 0", io.cmd_ready_o); end
        @(negedge clk_i);
        set_resp(1'b0, '0);
        #1;
        checks++; if (outstanding_o !== 3'd3) begin errors++; $display("FAIL free_count got %0d exp 3", outstanding_o); end
        checks++; if (io.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL free_ready got %0b exp 1", io.cmd_ready_o); end
        @(negedge clk_i);
        io.cmd_v_i = 1'b0;
        #1;
        checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL free_refill got %0d exp 4", outstanding_o); end
    endtask

    task automatic test_same_cycle();
        set_resp(1'b1, 32'hbeef_0002);
        @(negedge clk_i);
        #1;
        checks++; if (outstanding_o !== 3'd3) begin errors++; $display("FAIL same_pre_count got %0d exp 3", outstanding_o); end
        io.cmd_v_i = 1'b1;
        #1;
        checks++; if (io.cmd_v_o !== 1'b1) begin errors++; $display("FAIL same_cmd_v got %0b exp 1", io.cmd_v_o); end
        @(negedge clk_i);
        io.cmd_v_i = 1'b0;
        set_resp(1'b0, '0);
        #1;
        checks++; if (outstanding_o !== 3'd3) begin errors++; $display("FAIL same_count got %0d exp 3", outstanding_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL same_err got %0b exp 0", err_o); end
    endtask

    task automatic test_fence();
        set_resp(1'b1, 32'hbeef_0003);
        @(negedge clk_i);
        set_resp(1'b0, '0);
        fence_i    = 1'b1;
        io.cmd_v_i = 1'b1;
        #1;
        checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL fence_pre_count got %0d exp 2", outstanding_o); end
        checks++; if (io.cmd_v_o !== 1'b1) begin errors++; $display("FAIL fence_edge_cmd_v got %0b exp 1", io.cmd_v_o); end
        @(negedge clk_i);
        #1;
        checks++; if (state_o !== 1'b1) begin errors++; $display("FAIL fence_state got %0b exp FENCE", state_o); end
        checks++; if (outstanding_o !== 3'd3) begin errors++; $display("FAIL fence_count got %0d exp 3", outstanding_o); end
        checks++; if (io.cmd_v_o !== 1'b0) begin errors++; $display("FAIL fence_block_v got %0b exp 0", io.cmd_v_o); end
        checks++; if (io.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL fence_block_ready got %0b exp 0", io.cmd_ready_o); end
        for (int k = 0; k < 3; k++) begin
            set_resp(1'b1, 32'hbeef_0010 + k);
            #1;
            checks++; if (fence_done_o !== 1'b0) begin errors++; $display("FAIL fence_done_early k=%0d got %0b exp 0", k, fence_done_o); end
            @(negedge clk_i);
        end
        set_resp(1'b0, '0);
        #1;
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL fence_drain got %0d exp 0", outstanding_o); end
        checks++; if (fence_done_o !== 1'b1) begin errors++; $display("FAIL fence_done got %0b exp 1", fence_done_o); end
        fence_i = 1'b0;
        #1;
        checks++; if (io.cmd_v_o !== 1'b0) begin errors++; $display("FAIL fence_release_cycle got %0b exp 0", io.cmd_v_o); end
        @(negedge clk_i);
        #1;
        checks++; if (io.cmd_v_o !== 1'b1) begin errors++; $display("FAIL fence_resume got %0b exp 1", io.cmd_v_o); end
        @(negedge clk_i);
        io.cmd_v_i = 1'b0;
        #1;
        checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL fence_resume_count got %0d exp 1", outstanding_o); end
    endtask

    task automatic test_fence_empty();
        set_resp(1'b1, 32'hbeef_0020);
        @(negedge clk_i);
        set_resp(1'b0, '0);
        fence_i = 1'b1;
        #1;
        checks++; if (fence_done_o !== 1'b0) begin errors++; $display("FAIL empty_done_same got %0b exp 0", fence_done_o); end
        @(negedge clk_i);
        #1;
        checks++; if (fence_done_o !== 1'b1) begin errors++; $display("FAIL empty_done_next got %0b exp 1", fence_done_o); end
        fence_i = 1'b0;
        @(negedge clk_i);
        #1;
        checks++; if (fence_done_o !== 1'b0) begin errors++; $display("FAIL empty_done_clear got %0b exp 0", fence_done_o); end
        checks++; if (state_o !== 1'b0) begin errors++; $display("FAIL empty_state got %0b exp RUN", state_o); end
    endtask

    task automatic test_underflow();
        set_resp(1'b1, 32'h0bad_0001);
        #1;
        checks++; if (io.resp_v_o !== 1'b1) begin errors++; $display("FAIL under_resp_v got %0b exp 1", io.resp_v_o); end
        checks++; if (io.resp_o !== 32'h0bad_0001) begin errors++; $display("FAIL under_resp_data got %0h exp 0bad0001", io.resp_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL under_err_early got %0b exp 0", err_o); end
        @(negedge clk_i);
        set_resp(1'b0, '0);
        #1;
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL under_count got %0d exp 0", outstanding_o); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL under_err got %0b exp 1", err_o); end
        repeat (3) @(negedge clk_i);
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL under_err_sticky got %0b exp 1", err_o); end
    endtask

    task automatic test_watchdog();
        reset_i = 1'b1;
        #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL wd_reset_err got %0b exp 0", err_o); end
        @(negedge clk_i);
        reset_i    = 1'b0;
        io.cmd_i   = 32'hc0de_0001;
        io.cmd_v_i = 1'b1;
        @(negedge clk_i);
        io.cmd_v_i = 1'b0;
        #1;
        checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL wd_count got %0d exp 1", outstanding_o); end
        repeat (31) @(negedge clk_i);
        #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL wd_err_before got %0b exp 0", err_o); end
        @(negedge clk_i);
        #1;
`ifdef BP_IO_THROTTLE_WATCHDOG_EN
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL wd_err_timeout got %0b exp 1", err_o); end
`else
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL wd_err_disabled got %0b exp 0", err_o); end
`endif
        #2;
        reset_i = 1'b1;
        #1;
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL async_rst_count got %0d exp 0", outstanding_o); end
        checks++; if (io.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL async_rst_ready got %0b exp 0", io.cmd_ready_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL async_rst_err got %0b exp 0", err_o); end
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_credit_limit();
        test_resp_frees();
        test_same_cycle();
        test_fence();
        test_fence_empty();
        test_underflow();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
